deparse_act_scheduler: RTL and testbench
========================================

// Module: deparse_act_scheduler
// PURPOSE
//  Sequences one packet's deparse-action list across C_NUM_LANES sub-deparser lanes.
//  Lanes are 1-cycle-registered PHV container extractors.
//  Writes each returned 2B/4B/6B container value back into the packet header buffer at the action's byte offset.
//  Emits the rebuilt header with a valid/ready handshake.
//  Sits between the last match-action stage (PHV + action list in) and the packet merge/output logic.
// PARAMETERS
//  C_PKT_VEC_WIDTH  1124  PHV width; passed unchanged to the lanes
//  C_NUM_ACTS       10    deparse actions per packet
//  C_ACT_LEN        16    bits per action: [12:6] byte offset, [5:4] size, [3:1] index, [0] valid
//  C_NUM_LANES      2     sub-deparser lanes driven in parallel; must divide C_NUM_ACTS
//  C_HDR_WIDTH      1024  header buffer width (C_HDR_BYTES = 128)
// PORTS
//  clk                clk  in   1                       clock
//  aresetn            in   1                            reset, synchronous, active-low
//  phv_valid_in       in   1                            packet offered
//  phv_in             in   C_PKT_VEC_WIDTH              PHV of offered packet
//  parse_acts_in      in   C_NUM_ACTS*C_ACT_LEN         action list; action 0 in LSBs
//  hdr_in             in   C_HDR_WIDTH                  original header bytes
//  phv_ready_out      out  1                            accept; high only in IDLE
//  lane_act_valid     out  C_NUM_LANES                  per-lane parse_act_valid
//  lane_act           out  C_NUM_LANES*6                per-lane parse_act[5:0]
//  lane_phv           out  C_PKT_VEC_WIDTH              latched PHV shared by all lanes
//  lane_val_valid     in   C_NUM_LANES                  lane result valid
//  lane_val           in   C_NUM_LANES*48               lane result; 2B in [15:0], 4B in [31:0]
//  lane_val_type      in   C_NUM_LANES*2                01=2B 10=4B 11=6B 00=no data
//  hdr_valid_out      out  1                            rebuilt header valid
//  hdr_out            out  C_HDR_WIDTH                  rebuilt header
//  hdr_ready_in       in   1                            downstream accept
//  err_out            out  1                            sticky: some write exceeded the header; clears on next accept
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, header buffer, counters and in-flight tags cleared.
//   Reset mid-packet abandons the packet; no partial hdr_valid_out.
//  Header byte k occupies hdr[C_HDR_WIDTH-1-8k -: 8]. Fields are big-endian: value MSB goes to byte offset.
//  G = C_NUM_ACTS/C_NUM_LANES issue groups.
//  FSM IDLE -> ISSUE -> DRAIN -> OUTPUT -> IDLE.
//   IDLE: phv_ready_out=1. On phv_valid_in latch phv, acts and hdr into the buffer; clear grp_cnt and err_out.
//   ISSUE (G cycles): lane j gets action grp_cnt*L+j.
//    lane_act = act[5:0]; lane_act_valid = act[0].
//    Latch {offset, valid} per lane into a 1-deep in-flight tag.
//    grp_cnt+1 each cycle; at grp_cnt==G-1 go to DRAIN.
//   DRAIN (1 cycle): no issue (lane_act_valid=0); absorbs last group's results.
//   OUTPUT: hdr_valid_out=1 with stable hdr_out until hdr_ready_in; then IDLE.
//  Latency: accept at cycle 0, issue cycles 1..G, hdr_valid_out from cycle G+2. Defaults: cycle 7.
//   Next accept no earlier than the cycle after the handshake.
//  Write-back: a lane result seen at cycle t pairs with that lane's tag issued at t-1.
//   Write only if lane_val_valid && tag.valid && type!=00.
//   Bytes written: 2/4/6 for type 01/10/11, at offset..offset+n-1.
//  Bounds: if offset+n > C_HDR_BYTES, drop the whole write and set err_out. No partial or wrapped write.
//  Overlap: a later action index overwrites an earlier one. Same cycle: the higher lane wins.
//  lane_val_valid outside an in-flight slot is ignored.
//  hdr_ready_in outside OUTPUT is ignored. phv_valid_in outside IDLE is ignored (not latched).
// STRUCTURE
//  Shared package: action field positions, size codes (01/10/11) with byte counts, FSM state encoding.
//  Sub-module hdr_field_writer: one per lane.
//   In: buffer, offset, type, value. Out: merged buffer and oob flag.
//   Chain lanes in ascending order so the higher lane wins.
// TESTING
//  1 Single act 0x0043 (off 1, 2B idx1), lane returns 0xBEEF type 01 -> hdr bytes 1,2 = BE,EF; rest = hdr_in; valid at cycle 7.
//  2 All 10 acts valid, distinct offsets, mixed 2/4/6B -> every field at its offset, big-endian; err_out=0.
//  3 Act 6B at offset 125 -> buffer unchanged, err_out=1; next accepted packet clears err_out.
//  4 Acts 0 and 1 both write offset 4 (same cycle, lanes 0,1) -> lane 1 value kept; repeat across groups -> later group kept.
//  5 hdr_ready_in low 20 cycles -> hdr_out stable, phv_ready_out=0, new phv_valid_in ignored; accepted after handshake.
//  6 aresetn low during ISSUE -> all outputs 0, IDLE next cycle; following packet rebuilds correctly.

Source files
------------

// File: rtl/deparse_act_scheduler_pkg.sv
// Shared definitions for the deparse-action scheduler: action field layout,
// lane result size codes and the FSM state encoding.
package deparse_act_scheduler_pkg;

    localparam int ACT_VALID_BIT = 0;
    localparam int ACT_IDX_LSB   = 1;
    localparam int ACT_SIZE_LSB  = 4;
    localparam int ACT_OFF_LSB   = 6;
    localparam int ACT_OFF_W     = 7;
    localparam int LANE_ACT_W    = 6;
    localparam int LANE_VAL_W    = 48;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_2B   = 2'b01;
    localparam logic [1:0] SZ_4B   = 2'b10;
    localparam logic [1:0] SZ_6B   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] val_type);
        case (val_type)
            SZ_2B:   size_bytes = 4'd2;
            SZ_4B:   size_bytes = 4'd4;
            SZ_6B:   size_bytes = 4'd6;
            default: size_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/deparse_act_scheduler_hdr_field_writer.sv
// Merges one lane's 2/4/6-byte container value big-endian into the header
// buffer at a byte offset; an out-of-range write is dropped whole and flagged.
module deparse_act_scheduler_hdr_field_writer
    import deparse_act_scheduler_pkg::*;
#(
    parameter int C_HDR_WIDTH = 1024
) (
    input  logic                   en,
    input  logic [C_HDR_WIDTH-1:0] hdr_in,
    input  logic [ACT_OFF_W-1:0]   offset,
    input  logic [1:0]             val_type,
    input  logic [LANE_VAL_W-1:0]  value,
    output logic [C_HDR_WIDTH-1:0] hdr_out,
    output logic                   oob
);

    localparam int         HDR_BYTES   = C_HDR_WIDTH / 8;
    localparam logic [8:0] HDR_BYTES_W = 9'(HDR_BYTES);

    logic [3:0]            n_bytes;
    logic [8:0]            off_w;
    logic [8:0]            end_pos;
    logic [8:0]            rel;
    logic [LANE_VAL_W-1:0] aligned;
    logic [7:0]            vb [8];
    logic                  wr;

    always_comb begin
        n_bytes = size_bytes(val_type);
        off_w   = {2'b00, offset};
        end_pos = off_w + {5'b0, n_bytes};
        // left-justify so the value's MSB byte always sits in vb[0]
        case (val_type)
            SZ_2B:   aligned = {value[15:0], 32'h0};
            SZ_4B:   aligned = {value[31:0], 16'h0};
            default: aligned = value;
        endcase
        for (int i = 0; i < 8; i++) begin
            vb[i] = (i < 6) ? aligned[LANE_VAL_W-1-8*i -: 8] : 8'h00;
        end
        oob     = en && (val_type != SZ_NONE) && (end_pos > HDR_BYTES_W);
        wr      = en && (val_type != SZ_NONE) && !oob;
        hdr_out = hdr_in;
        rel     = '0;
        for (int k = 0; k < HDR_BYTES; k++) begin
            rel = 9'(k) - off_w;
            if (wr && (9'(k) >= off_w) && (9'(k) < end_pos)) begin
                hdr_out[C_HDR_WIDTH-1-8*k -: 8] = vb[rel[2:0]];
            end
        end
    end

endmodule

// File: rtl/deparse_act_scheduler.sv
// Issues one packet's deparse actions across parallel extractor lanes, writes
// the returned container values into the header buffer and emits the result.
module deparse_act_scheduler
    import deparse_act_scheduler_pkg::*;
#(
    parameter int C_PKT_VEC_WIDTH = 1124,
    parameter int C_NUM_ACTS      = 10,
    parameter int C_ACT_LEN       = 16,
    parameter int C_NUM_LANES     = 2,
    parameter int C_HDR_WIDTH     = 1024
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic                              phv_valid_in,
    input  logic [C_PKT_VEC_WIDTH-1:0]        phv_in,
    input  logic [C_NUM_ACTS*C_ACT_LEN-1:0]   parse_acts_in,
    input  logic [C_HDR_WIDTH-1:0]            hdr_in,
    output logic                              phv_ready_out,
    output logic [C_NUM_LANES-1:0]            lane_act_valid,
    output logic [C_NUM_LANES*LANE_ACT_W-1:0] lane_act,
    output logic [C_PKT_VEC_WIDTH-1:0]        lane_phv,
    input  logic [C_NUM_LANES-1:0]            lane_val_valid,
    input  logic [C_NUM_LANES*LANE_VAL_W-1:0] lane_val,
    input  logic [C_NUM_LANES*2-1:0]          lane_val_type,
    output logic                              hdr_valid_out,
    output logic [C_HDR_WIDTH-1:0]            hdr_out,
    input  logic                              hdr_ready_in,
    output logic                              err_out
);

    localparam int             G      = C_NUM_ACTS / C_NUM_LANES;
    localparam int             GW     = (G > 1) ? $clog2(G) : 1;
    localparam logic [GW-1:0]  G_LAST = GW'(G - 1);

    state_t                         state, state_nxt;
    logic [GW-1:0]                  grp_cnt;
    logic [C_PKT_VEC_WIDTH-1:0]     phv_q;
    logic [C_NUM_ACTS*C_ACT_LEN-1:0] acts_q;
    logic [C_HDR_WIDTH-1:0]         hdr_q;
    logic                           err_q;
    logic [C_NUM_LANES-1:0]         tag_valid;
    logic [ACT_OFF_W-1:0]           tag_off [C_NUM_LANES];
    logic [C_ACT_LEN-1:0]           act_arr [G][C_NUM_LANES];
    logic [C_ACT_LEN-1:0]           grp_act [C_NUM_LANES];
    logic [C_HDR_WIDTH-1:0]         chain [C_NUM_LANES+1];
    logic [C_NUM_LANES-1:0]         lane_oob;
    logic [C_NUM_LANES-1:0]         act_hi_unused;
    logic                           accept;
    logic                           issue;

    for (genvar g = 0; g < G; g++) begin : g_grp
        for (genvar j = 0; j < C_NUM_LANES; j++) begin : g_act
            assign act_arr[g][j] = acts_q[(g*C_NUM_LANES+j)*C_ACT_LEN +: C_ACT_LEN];
        end
    end

    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        issue          = 1'b0;
        lane_act_valid = '0;
        lane_act       = '0;
        act_hi_unused  = '0;
        case (state)
            S_IDLE: begin
                accept = phv_valid_in;
                if (phv_valid_in) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                issue = 1'b1;
                if (grp_cnt == G_LAST) state_nxt = S_DRAIN;
            end
            S_DRAIN:  state_nxt = S_OUTPUT;
            S_OUTPUT: if (hdr_ready_in) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        for (int j = 0; j < C_NUM_LANES; j++) begin
            grp_act[j]       = act_arr[grp_cnt][j];
            act_hi_unused[j] = ^grp_act[j][C_ACT_LEN-1:ACT_OFF_LSB+ACT_OFF_W];
            if (issue) begin
                lane_act_valid[j]                     = grp_act[j][ACT_VALID_BIT];
                lane_act[j*LANE_ACT_W +: LANE_ACT_W]  = grp_act[j][LANE_ACT_W-1:0];
            end
        end
    end

    // ready is masked while reset is held so every output reads 0 during reset
    assign phv_ready_out = aresetn && (state == S_IDLE);
    assign hdr_valid_out = (state == S_OUTPUT);
    assign hdr_out       = hdr_q;
    assign lane_phv      = phv_q;
    assign err_out       = err_q;

    assign chain[0] = hdr_q;
    for (genvar j = 0; j < C_NUM_LANES; j++) begin : g_lane
        deparse_act_scheduler_hdr_field_writer #(
            .C_HDR_WIDTH (C_HDR_WIDTH)
        ) u_hdr_field_writer (
            .en       (tag_valid[j] && lane_val_valid[j]),
            .hdr_in   (chain[j]),
            .offset   (tag_off[j]),
            .val_type (lane_val_type[2*j +: 2]),
            .value    (lane_val[j*LANE_VAL_W +: LANE_VAL_W]),
            .hdr_out  (chain[j+1]),
            .oob      (lane_oob[j])
        );
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            grp_cnt   <= '0;
            phv_q     <= '0;
            acts_q    <= '0;
            hdr_q     <= '0;
            err_q     <= 1'b0;
            tag_valid <= '0;
            for (int j = 0; j < C_NUM_LANES; j++) tag_off[j] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                phv_q   <= phv_in;
                acts_q  <= parse_acts_in;
                hdr_q   <= hdr_in;
                err_q   <= 1'b0;
                grp_cnt <= '0;
            end else begin
                hdr_q <= chain[C_NUM_LANES];
                if (|lane_oob) err_q <= 1'b1;
                if (issue) grp_cnt <= grp_cnt + 1'b1;
            end
            // one-deep tag: pairs with the lane result returned next cycle
            for (int j = 0; j < C_NUM_LANES; j++) begin
                tag_valid[j] <= issue && grp_act[j][ACT_VALID_BIT];
                tag_off[j]   <= grp_act[j][ACT_OFF_LSB +: ACT_OFF_W];
            end
        end
    end

endmodule

// File: tb/tb_deparse_act_scheduler.sv
// Directed bench for deparse_act_scheduler: table of packets with a
// behavioural lane model and a byte-level header reference.
module tb_deparse_act_scheduler;

    localparam int PW = 1124;
    localparam int NA = 10;
    localparam int AL = 16;
    localparam int NL = 2;
    localparam int HW = 1024;

    typedef struct {
        string          name;
        logic [NA*AL-1:0] acts;
        logic [HW-1:0]  hdr;
        logic [8*48-1:0] vals;
        logic [15:0]    types;
        logic           exp_err;
        int             hold;
    } vec_t;

    logic              clk;
    logic              aresetn;
    logic              phv_valid_in;
    logic [PW-1:0]     phv_in;
    logic [NA*AL-1:0]  parse_acts_in;
    logic [HW-1:0]     hdr_in;
    logic              phv_ready_out;
    logic [NL-1:0]     lane_act_valid;
    logic [NL*6-1:0]   lane_act;
    logic [PW-1:0]     lane_phv;
    logic [NL-1:0]     lane_val_valid = '0;
    logic [NL*48-1:0]  lane_val = '0;
    logic [NL*2-1:0]   lane_val_type = '0;
    logic              hdr_valid_out;
    logic [HW-1:0]     hdr_out;
    logic              hdr_ready_in;
    logic              err_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8*48-1:0] cur_vals  = '0;
    logic [15:0]     cur_types = '0;
    logic [NL-1:0]   pv = '0;
    logic [5:0]      pact [NL];

    vec_t vecs [5];

    deparse_act_scheduler dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .phv_valid_in   (phv_valid_in),
        .phv_in         (phv_in),
        .parse_acts_in  (parse_acts_in),
        .hdr_in         (hdr_in),
        .phv_ready_out  (phv_ready_out),
        .lane_act_valid (lane_act_valid),
        .lane_act       (lane_act),
        .lane_phv       (lane_phv),
        .lane_val_valid (lane_val_valid),
        .lane_val       (lane_val),
        .lane_val_type  (lane_val_type),
        .hdr_valid_out  (hdr_valid_out),
        .hdr_out        (hdr_out),
        .hdr_ready_in   (hdr_ready_in),
        .err_out        (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Lane model: 1-cycle extractor; idle lanes return junk that must be ignored.
    always @(negedge clk) begin
        for (int j = 0; j < NL; j++) begin
            pv[j]   = lane_act_valid[j];
            pact[j] = lane_act[6*j +: 6];
        end
    end

    always @(posedge clk) begin
        #1;
        for (int j = 0; j < NL; j++) begin
            lane_val_valid[j] = 1'b1;
            if (pv[j]) begin
                lane_val[48*j +: 48]     = cur_vals[48*int'(pact[j][3:1]) +: 48];
                lane_val_type[2*j +: 2]  = cur_types[2*int'(pact[j][3:1]) +: 2];
            end else begin
                lane_val[48*j +: 48]     = 48'hFFFF_FFFF_FFFF;
                lane_val_type[2*j +: 2]  = 2'b11;
            end
        end
    end

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_hdr(input string name, input logic [HW-1:0] got, input logic [HW-1:0] exp);
        check({name, "_hi"}, got[HW-1:512], exp[HW-1:512]);
        check({name, "_lo"}, got[511:0], exp[511:0]);
    endtask

    task automatic check_phv(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        check({name, "_top"}, 512'(got[PW-1:1024]), 512'(exp[PW-1:1024]));
        check({name, "_mid"}, got[1023:512], exp[1023:512]);
        check({name, "_low"}, got[511:0], exp[511:0]);
    endtask

    function automatic logic [15:0] mk_act(input int off, input int sz, input int idx, input bit v);
        mk_act = {3'b000, 7'(off), 2'(sz), 3'(idx), v};
    endfunction

    function automatic logic [HW-1:0] mk_hdr(input int seed);
        logic [HW-1:0] h;
        for (int k = 0; k < HW/8; k++) h[HW-1-8*k -: 8] = 8'(k*7 + seed);
        return h;
    endfunction

    function automatic logic [HW-1:0] ref_hdr(input logic [HW-1:0] h_in, input logic [NA*AL-1:0] acts,
                                             input logic [8*48-1:0] vals, input logic [15:0] types,
                                             output logic err);
        logic [HW-1:0] h;
        logic [15:0]   a;
        logic [47:0]   v;
        int idx, n, off, t;
        h   = h_in;
        err = 1'b0;
        for (int i = 0; i < NA; i++) begin
            a = acts[16*i +: 16];
            if (a[0]) begin
                idx = int'(a[3:1]);
                t   = int'(types[2*idx +: 2]);
                n   = 2 * t;
                off = int'(a[12:6]);
                v   = vals[48*idx +: 48];
                if (n != 0) begin
                    if (off + n > HW/8) err = 1'b1;
                    else for (int b = 0; b < n; b++) h[HW-1-8*(off+b) -: 8] = v[8*(n-1-b) +: 8];
                end
            end
        end
        return h;
    endfunction

    task automatic run_pkt(input vec_t v);
        logic [PW-1:0] phv;
        logic [HW-1:0] exp_h;
        logic          exp_e;
        int            c;
        exp_h = ref_hdr(v.hdr, v.acts, v.vals, v.types, exp_e);
        for (int b = 0; b < PW; b++) phv[b] = 1'($urandom_range(0, 1));
        cur_vals  = v.vals;
        cur_types = v.types;
        @(posedge clk) #1;
        check({v.name, "_ready_idle"}, 512'(phv_ready_out), 512'(1));
        phv_valid_in  = 1'b1;
        phv_in        = phv;
        parse_acts_in = v.acts;
        hdr_in        = v.hdr;
        @(posedge clk) #1;
        phv_valid_in  = 1'b0;
        hdr_in        = ~v.hdr;
        parse_acts_in = '0;
        check_phv({v.name, "_lane_phv"}, lane_phv, phv);
        check({v.name, "_first_act_valid"}, 512'(lane_act_valid), 512'({v.acts[16], v.acts[0]}));
        check({v.name, "_first_act"}, 512'(lane_act), 512'({v.acts[21:16], v.acts[5:0]}));
        check({v.name, "_err_cleared"}, 512'(err_out), 512'(0));
        check({v.name, "_ready_busy"}, 512'(phv_ready_out), 512'(0));
        c = 1;
        while (!hdr_valid_out && c < 40) begin
            @(posedge clk) #1;
            c++;
        end
        check({v.name, "_latency"}, 512'(c), 512'(7));
        check_hdr({v.name, "_hdr"}, hdr_out, exp_h);
        check({v.name, "_err"}, 512'(err_out), 512'(v.exp_err));
        for (int h = 0; h < v.hold; h++) begin
            hdr_ready_in  = 1'b0;
            phv_valid_in  = 1'b1;
            phv_in        = ~phv;
            hdr_in        = '0;
            parse_acts_in = '1;
            @(posedge clk) #1;
            check({v.name, "_hold_valid"}, 512'(hdr_valid_out), 512'(1));
            check({v.name, "_hold_ready"}, 512'(phv_ready_out), 512'(0));
            check_hdr({v.name, "_hold_hdr"}, hdr_out, exp_h);
        end
        phv_valid_in = 1'b0;
        hdr_ready_in = 1'b1;
        @(posedge clk) #1;
        hdr_ready_in = 1'b0;
        check({v.name, "_post_valid"}, 512'(hdr_valid_out), 512'(0));
        check({v.name, "_post_ready"}, 512'(phv_ready_out), 512'(1));
        check_phv({v.name, "_post_phv"}, lane_phv, phv);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            vecs[i].acts  = '0;
            vecs[i].vals  = '0;
            vecs[i].types = '0;
            vecs[i].hold  = 0;
            vecs[i].exp_err = 1'b0;
            vecs[i].hdr   = mk_hdr(i * 13 + 1);
        end
        // single 2B write of 0xBEEF at byte 1
        vecs[0].name = "single";
        vecs[0].acts[15:0] = 16'h0043;
        vecs[0].vals[48*1 +: 48] = 48'h0000_0000_BEEF;
        vecs[0].types[2*1 +: 2]  = 2'b01;
        // all ten actions, mixed sizes, disjoint offsets; held output for 20 cycles
        vecs[1].name = "all_acts";
        vecs[1].hold = 20;
        for (int i = 0; i < 8; i++) begin
            vecs[1].vals[48*i +: 48]  = 48'hA1B2_C3D4_E5F6 ^ {6{8'(i*17 + 3)}};
            vecs[1].types[2*i +: 2]   = 2'((i % 3) + 1);
        end
        for (int a = 0; a < NA; a++)
            vecs[1].acts[16*a +: 16] = mk_act(3 + a*9, (a % 3) + 1, a % 8, 1'b1);
        // 6B at 125 overflows; 6B at 122 and 2B at 0 land exactly on the edges
        vecs[2].name = "bounds";
        vecs[2].exp_err = 1'b1;
        vecs[2].acts[16*0 +: 16] = mk_act(125, 3, 2, 1'b1);
        vecs[2].acts[16*1 +: 16] = mk_act(122, 3, 5, 1'b1);
        vecs[2].acts[16*3 +: 16] = mk_act(0, 1, 3, 1'b1);
        vecs[2].vals[48*2 +: 48] = 48'h0102_0304_0506;
        vecs[2].vals[48*5 +: 48] = 48'h1122_3344_5566;
        vecs[2].vals[48*3 +: 48] = 48'h0000_0000_CAFE;
        vecs[2].types = {2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00};
        // overlap: same cycle lanes 0/1 at byte 4, then groups 1 and 2 at byte 20
        vecs[3].name = "overlap";
        vecs[3].acts[16*0 +: 16] = mk_act(4, 1, 0, 1'b1);
        vecs[3].acts[16*1 +: 16] = mk_act(4, 1, 1, 1'b1);
        vecs[3].acts[16*2 +: 16] = mk_act(20, 2, 2, 1'b1);
        vecs[3].acts[16*4 +: 16] = mk_act(20, 2, 3, 1'b1);
        vecs[3].acts[16*9 +: 16] = mk_act(126, 1, 4, 1'b1);
        vecs[3].vals[48*0 +: 48] = 48'h0000_0000_1111;
        vecs[3].vals[48*1 +: 48] = 48'h0000_0000_2222;
        vecs[3].vals[48*2 +: 48] = 48'h0000_3333_3333;
        vecs[3].vals[48*3 +: 48] = 48'h0000_4444_4444;
        vecs[3].vals[48*4 +: 48] = 48'h0000_0000_9ABC;
        vecs[3].types = {2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
        // invalid action and a no-data result must not write
        vecs[4].name = "no_write";
        vecs[4].acts[16*0 +: 16] = mk_act(10, 1, 1, 1'b0);
        vecs[4].acts[16*3 +: 16] = mk_act(30, 0, 6, 1'b1);
        vecs[4].acts[16*5 +: 16] = mk_act(50, 3, 7, 1'b1);
        vecs[4].vals[48*1 +: 48] = 48'h0000_0000_DEAD;
        vecs[4].vals[48*6 +: 48] = 48'h0000_0000_BAAD;
        vecs[4].vals[48*7 +: 48] = 48'hFEDC_BA98_7654;
        vecs[4].types = {2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};

        aresetn       = 1'b0;
        phv_valid_in  = 1'b0;
        phv_in        = '0;
        parse_acts_in = '0;
        hdr_in        = '0;
        hdr_ready_in  = 1'b0;
        repeat (3) @(posedge clk) #1;
        check("rst_ready", 512'(phv_ready_out), 512'(0));
        check("rst_hdr_valid", 512'(hdr_valid_out), 512'(0));
        check("rst_act_valid", 512'(lane_act_valid), 512'(0));
        check("rst_err", 512'(err_out), 512'(0));
        check_hdr("rst_hdr", hdr_out, '0);
        aresetn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_pkt(vecs[i]);
            if (i == 0) begin
                check("single_bytes12", 512'(hdr_out[HW-9 -: 16]), 512'(16'hBEEF));
                check("single_byte0", 512'(hdr_out[HW-1 -: 8]), 512'(8'h01));
            end
        end

        // reset during ISSUE abandons the packet
        cur_vals  = vecs[1].vals;
        cur_types = vecs[1].types;
        @(posedge clk) #1;
        phv_valid_in  = 1'b1;
        phv_in        = '1;
        parse_acts_in = vecs[1].acts;
        hdr_in        = vecs[1].hdr;
        @(posedge clk) #1;
        phv_valid_in = 1'b0;
        @(posedge clk) #1;
        aresetn = 1'b0;
        @(posedge clk) #1;
        check("midrst_ready", 512'(phv_ready_out), 512'(0));
        check("midrst_hdr_valid", 512'(hdr_valid_out), 512'(0));
        check("midrst_act_valid", 512'(lane_act_valid), 512'(0));
        check("midrst_act", 512'(lane_act), 512'(0));
        check("midrst_err", 512'(err_out), 512'(0));
        check_hdr("midrst_hdr", hdr_out, '0);
        check_phv("midrst_phv", lane_phv, '0);
        aresetn = 1'b1;
        @(posedge clk) #1;
        check("midrst_idle", 512'(phv_ready_out), 512'(1));
        check("midrst_no_valid", 512'(hdr_valid_out), 512'(0));
        vecs[3].name = "after_rst";
        run_pkt(vecs[3]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
